// File: rtl/rk4_cal_pkg.sv
// rk4_cal_pkg: shared types and constants for the RK4 clock calibration block.
// Imported by rk4_edge_counter and rk4_clk_cal.
package rk4_cal_pkg;

   typedef enum logic [2:0] {
      IDLE,
      SETTLE,
      MEASURE,
      COMPARE,
      DONE
   } state_t;

   localparam int         NUM_OSC        = 3;
   localparam logic [1:0] SEL_EXT        = 2'b11;
   localparam int         OSC_RST_CYCLES = 4;

endpackage

// File: rtl/rk4_edge_counter.sv
// rk4_edge_counter: synchronizes the divided oscillator clock and counts
// its rising edges with clear/enable and saturation.
module rk4_edge_counter #(
   parameter int CNT_W       = 16,
   parameter int SYNC_STAGES = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             din,
   input  logic             clr,
   input  logic             en,
   output logic [CNT_W-1:0] count
);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   prev_q;
   logic                   rise;

   // Free-running so the edge history is valid when a window opens.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q <= '0;
         prev_q <= 1'b0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], din};
         prev_q <= sync_q[SYNC_STAGES-1];
      end
   end

   assign rise = sync_q[SYNC_STAGES-1] & ~prev_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= '0;
      end else if (clr) begin
         count <= '0;
      end else if (en && rise && (count != '1)) begin
         count <= count + 1'b1;
      end
   end

endmodule

// File: rtl/rk4_clk_cal.sv
// rk4_clk_cal: sweeps the three ring oscillators and keeps the closest to target.
// Define RK4_CLK_CAL_ABORT_EN to add the abort input and aborted output.
module rk4_clk_cal
   import rk4_cal_pkg::*;
#(
   parameter int CNT_W         = 16,
   parameter int GATE_W        = 16,
   parameter int SYNC_STAGES   = 2,
   parameter int SETTLE_CYCLES = 64
) (
   input  logic              clk_in,
   input  logic              rst_n,
   input  logic              start,
   input  logic [GATE_W-1:0] gate_len,
   input  logic [CNT_W-1:0]  target,
   input  logic              osc_div_in,
`ifdef RK4_CLK_CAL_ABORT_EN
   input  logic              abort,
   output logic              aborted,
`endif
   output logic              osc_en,
   output logic              osc_rst,
   output logic [1:0]        sel,
   output logic              busy,
   output logic              done,
   output logic [1:0]        best_sel,
   output logic [CNT_W-1:0]  best_count,
   output logic              meas_valid,
   output logic [1:0]        meas_idx,
   output logic [CNT_W-1:0]  meas_count
);

   localparam int SET_W = ($clog2(SETTLE_CYCLES) > 3) ? $clog2(SETTLE_CYCLES) : 3;
   localparam logic [SET_W-1:0] SETTLE_LAST = SET_W'(SETTLE_CYCLES - 1);
   localparam logic [SET_W-1:0] RST_LAST    = SET_W'(OSC_RST_CYCLES);
   localparam logic [1:0]       LAST_IDX    = 2'(NUM_OSC - 1);

   state_t             state_q, state_d;
   logic [1:0]         idx_q, best_sel_q, sel_raw, meas_idx_q;
   logic [SET_W-1:0]   settle_q;
   logic [GATE_W-1:0]  gate_q, win_q;
   logic [CNT_W-1:0]   target_q, count, best_count_q, meas_count_q;
   logic [CNT_W:0]     diff, err, best_err_q;
   logic               init_q, osc_en_q, meas_valid_q, better, abort_hit;

`ifdef RK4_CLK_CAL_ABORT_EN
   logic [1:0]         sv_sel_q;
   logic [CNT_W-1:0]   sv_count_q;
   logic [CNT_W:0]     sv_err_q;
   logic               aborted_q;

   assign abort_hit = abort && (state_q != IDLE);
   assign aborted   = aborted_q;
`else
   assign abort_hit = 1'b0;
`endif

   rk4_edge_counter #(
      .CNT_W       (CNT_W),
      .SYNC_STAGES (SYNC_STAGES)
   ) u_cnt (
      .clk   (clk_in),
      .rst_n (rst_n),
      .din   (osc_div_in),
      .clr   (state_q == SETTLE),
      .en    (state_q == MEASURE),
      .count (count)
   );

   always_ff @(posedge clk_in or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (start) state_d = SETTLE;
         SETTLE:  if (settle_q == SETTLE_LAST) state_d = MEASURE;
         MEASURE: if (win_q == gate_q - 1'b1) state_d = COMPARE;
         COMPARE: state_d = (idx_q == LAST_IDX) ? DONE : SETTLE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
      if (abort_hit) state_d = IDLE;
   end

   // Error kept one bit wider so |count-target| never wraps.
   always_comb begin
      diff   = {1'b0, count} - {1'b0, target_q};
      err    = diff[CNT_W] ? (~diff + 1'b1) : diff;
      better = (idx_q == 2'd0) || (err < best_err_q);
   end

   always_ff @(posedge clk_in or negedge rst_n) begin
      if (!rst_n) begin
         init_q       <= 1'b0;
         osc_en_q     <= 1'b0;
         settle_q     <= '0;
         win_q        <= '0;
         gate_q       <= '0;
         target_q     <= '0;
         idx_q        <= '0;
         best_sel_q   <= '0;
         best_count_q <= '0;
         best_err_q   <= '0;
         meas_valid_q <= 1'b0;
         meas_idx_q   <= '0;
         meas_count_q <= '0;
`ifdef RK4_CLK_CAL_ABORT_EN
         sv_sel_q     <= '0;
         sv_count_q   <= '0;
         sv_err_q     <= '0;
         aborted_q    <= 1'b0;
`endif
      end else begin
         init_q       <= 1'b1;
         meas_valid_q <= 1'b0;
         settle_q     <= (state_q == SETTLE) ? settle_q + 1'b1 : '0;
         win_q        <= (state_q == MEASURE) ? win_q + 1'b1 : '0;
         if (state_q == IDLE && start) begin
            gate_q   <= (gate_len == '0) ? GATE_W'(1) : gate_len;
            target_q <= target;
            idx_q    <= '0;
            osc_en_q <= 1'b1;
`ifdef RK4_CLK_CAL_ABORT_EN
            sv_sel_q   <= best_sel_q;
            sv_count_q <= best_count_q;
            sv_err_q   <= best_err_q;
`endif
         end
         if (state_q == COMPARE) begin
            meas_valid_q <= 1'b1;
            meas_idx_q   <= idx_q;
            meas_count_q <= count;
            if (better) begin
               best_sel_q   <= idx_q;
               best_count_q <= count;
               best_err_q   <= err;
            end
            if (idx_q != LAST_IDX) idx_q <= idx_q + 1'b1;
         end
`ifdef RK4_CLK_CAL_ABORT_EN
         aborted_q <= abort_hit;
         if (abort_hit) begin
            best_sel_q   <= sv_sel_q;
            best_count_q <= sv_count_q;
            best_err_q   <= sv_err_q;
         end
`endif
      end
   end

   always_comb begin
      sel_raw = idx_q;
      osc_rst = 1'b0;
      busy    = 1'b1;
      done    = 1'b0;
      unique case (state_q)
         IDLE: begin
            sel_raw = best_sel_q;
            osc_rst = !init_q;
            busy    = 1'b0;
         end
         SETTLE: osc_rst = (settle_q < RST_LAST);
         MEASURE, COMPARE: begin
         end
         DONE: begin
            sel_raw = best_sel_q;
            done    = 1'b1;
         end
         default: begin
            sel_raw = best_sel_q;
            busy    = 1'b0;
         end
      endcase
      // The external mux code is reserved for the clock generator.
      sel = (sel_raw == SEL_EXT) ? 2'b00 : sel_raw;
   end

   assign osc_en     = osc_en_q;
   assign best_sel   = best_sel_q;
   assign best_count = best_count_q;
   assign meas_valid = meas_valid_q;
   assign meas_idx   = meas_idx_q;
   assign meas_count = meas_count_q;

endmodule
